// File: rtl/ssmsg_scroller.sv
// Scrolls a buffered message of 5-bit decoder codes right-to-left across DIGITS positions.
// Optional SSMSG_LOOP_EN: repeat the message until stop instead of ending after one pass.
module ssmsg_scroller #(
  parameter int DIGITS      = 8,
  parameter int MSG_LEN     = 16,
  parameter int STEP_CYCLES = 25
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
  input  logic [4:0]                   wr_char,
  input  logic [$clog2(MSG_LEN+1)-1:0] msg_len,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic                         done,
  output logic [DIGITS*5-1:0]          codes,
  output logic [DIGITS-1:0]            enables
);

  localparam int AW  = $clog2(MSG_LEN);
  localparam int LW  = $clog2(MSG_LEN+1);
  localparam int PW  = $clog2(MSG_LEN+DIGITS);
  localparam int PSW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t         state;
  logic [PW-1:0]  pos;
  logic [PSW-1:0] presc;
  logic [LW-1:0]  len_reg;
  logic [4:0]     msg_mem [MSG_LEN];

  logic [LW-1:0]  len_clamped;
  logic [PW-1:0]  pos_next;
  logic [PW-1:0]  end_pos;

  assign len_clamped = (int'(msg_len) > MSG_LEN) ? LW'(MSG_LEN) : msg_len;
  assign pos_next    = pos + PW'(1);
  // First position at which every character has left the display.
  assign end_pos     = PW'(len_reg) + PW'(DIGITS-1);
  assign busy        = (state == SCROLL);

  // Message buffer is deliberately not reset; it is only writable while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE) && (int'(wr_addr) < MSG_LEN))
      msg_mem[wr_addr] <= wr_char;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      pos     <= '0;
      presc   <= '0;
      len_reg <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            len_reg <= len_clamped;
            pos     <= '0;
            presc   <= '0;
            if (msg_len == '0)
              done  <= 1'b1;
            else
              state <= SCROLL;
          end
        end
        SCROLL: begin
          if (stop) begin
            state <= IDLE;
            pos   <= '0;
            presc <= '0;
          end else if (presc == PSW'(STEP_CYCLES-1)) begin
            presc <= '0;
            if (pos_next == end_pos) begin
              done  <= 1'b1;
              pos   <= '0;
`ifdef SSMSG_LOOP_EN
              state <= SCROLL;
`else
              state <= IDLE;
`endif
            end else begin
              pos <= pos_next;
            end
          end else begin
            presc <= presc + PSW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit d shows message index pos-d when that index lies inside the message.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [PW:0] idx;
    logic        in_range;
    assign idx      = {1'b0, pos} - (PW+1)'(gi);
    assign in_range = (state == SCROLL) && ({1'b0, pos} >= (PW+1)'(gi)) &&
                      (idx < (PW+1)'(len_reg));
    assign enables[gi]         = in_range;
    assign codes[5*gi +: 5]    = in_range ? msg_mem[idx[AW-1:0]] : 5'd0;
  end

endmodule
